// File: rtl/xctrl2.sv
// xctrl2: single-issue accumulator controller with a call/return stack and a
// stallable external data port; one instruction retires per non-stalled cycle.
module xctrl2 #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int PROG_ADDR_W = 10,
    parameter int IMM_W       = 16,
    parameter int PROG_ROM    = 0,
    parameter int RB_ADDR     = 1,
    parameter int RC_ADDR     = 2,
    parameter int STACK_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [PROG_ADDR_W-1:0] pc,
    input  logic [IMM_W+3:0]       instruction,
    output logic                   data_sel,
    output logic                   data_we,
    output logic [ADDR_W-1:0]      data_addr,
    input  logic [DATA_W-1:0]      data_to_rd,
    output logic [DATA_W-1:0]      data_to_wr,
    input  logic                   data_ready
);

    typedef enum logic [3:0] {
        OP_ADDI  = 4'h0, OP_ADD   = 4'h1, OP_SUB   = 4'h2, OP_SHFT  = 4'h3,
        OP_AND   = 4'h4, OP_XOR   = 4'h5, OP_LDI   = 4'h6, OP_LDIH  = 4'h7,
        OP_RDW   = 4'h8, OP_WRW   = 4'h9, OP_RDWB  = 4'hA, OP_WRWB  = 4'hB,
        OP_BEQI  = 4'hC, OP_BNEQI = 4'hD, OP_CALL  = 4'hE, OP_RET   = 4'hF
    } op_e;

    localparam int                     SP_W    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W:0]          SP_FULL = (SP_W+1)'(STACK_DEPTH);
    localparam logic [SP_W:0]          SP_ONE  = (SP_W+1)'(1);
    localparam logic [ADDR_W-1:0]      RB_A    = ADDR_W'(RB_ADDR);
    localparam logic [ADDR_W-1:0]      RC_A    = ADDR_W'(RC_ADDR);
    localparam logic [PROG_ADDR_W-1:0] PC_RST  = PROG_ADDR_W'(PROG_ROM);
    localparam logic [PROG_ADDR_W-1:0] PC_ONE  = PROG_ADDR_W'(1);

    logic [PROG_ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0]      r_a;
    logic [DATA_W-1:0]      r_b;
    logic                   r_carry;
    logic                   r_ovf;
    logic                   r_neg;
    logic                   r_serr;
    logic [SP_W:0]          r_sp;
    logic [PROG_ADDR_W-1:0] r_stack [STACK_DEPTH];

    op_e                    w_op;
    logic [IMM_W-1:0]       w_imm;
    logic [DATA_W-1:0]      w_imm_ext;
    logic                   w_is_mem;
    logic [ADDR_W-1:0]      w_eff;
    logic                   w_int_b;
    logic                   w_int_c;
    logic                   w_stall;
    logic [DATA_W-1:0]      w_flags;
    logic [DATA_W-1:0]      w_operand;
    logic [DATA_W-1:0]      w_addend;
    logic [DATA_W:0]        w_sum;
    logic [DATA_W:0]        w_diff;
    logic                   w_add_ovf;
    logic                   w_sub_ovf;
    logic [DATA_W-1:0]      w_ldih;
    logic [PROG_ADDR_W-1:0] w_pc_inc;
    logic [PROG_ADDR_W-1:0] w_pc_rel;
    logic [SP_W-1:0]        w_top;

    assign w_op      = op_e'(instruction[IMM_W+3:IMM_W]);
    assign w_imm     = instruction[IMM_W-1:0];
    assign w_imm_ext = DATA_W'($signed(w_imm));

    assign w_is_mem = (w_op == OP_ADD)  || (w_op == OP_SUB)  || (w_op == OP_AND)  ||
                      (w_op == OP_XOR)  || (w_op == OP_RDW)  || (w_op == OP_WRW)  ||
                      (w_op == OP_RDWB) || (w_op == OP_WRWB);
    assign w_eff    = ((w_op == OP_RDWB) || (w_op == OP_WRWB))
                    ? r_b[ADDR_W-1:0] + w_imm[ADDR_W-1:0]
                    : w_imm[ADDR_W-1:0];
    assign w_int_b  = (w_eff == RB_A);
    assign w_int_c  = (w_eff == RC_A);

    // Request/ready handshake: data_sel (with data_we/data_addr) is raised
    // combinationally from the current instruction and held unchanged while
    // data_ready is low; the access completes and the instruction retires in
    // the first cycle where data_sel and data_ready are both high.
    assign data_sel   = w_is_mem && !w_int_b && !w_int_c;
    assign data_we    = data_sel && ((w_op == OP_WRW) || (w_op == OP_WRWB));
    assign data_addr  = w_eff;
    assign data_to_wr = r_a;
    assign pc         = r_pc;
    assign w_stall    = data_sel && !data_ready;

    always_comb begin
        w_flags           = '0;
        w_flags[0]        = r_carry;
        w_flags[1]        = r_serr;
        w_flags[DATA_W-2] = r_ovf;
        w_flags[DATA_W-1] = r_neg;
    end

    assign w_operand = w_int_b ? r_b : (w_int_c ? w_flags : data_to_rd);
    assign w_addend  = (w_op == OP_ADDI) ? w_imm_ext : w_operand;
    assign w_sum     = {1'b0, r_a} + {1'b0, w_addend};
    assign w_diff    = {1'b0, r_a} - {1'b0, w_operand};
    assign w_add_ovf = (r_a[DATA_W-1] == w_addend[DATA_W-1]) && (w_sum[DATA_W-1] != r_a[DATA_W-1]);
    assign w_sub_ovf = (r_a[DATA_W-1] != w_operand[DATA_W-1]) && (w_diff[DATA_W-1] != r_a[DATA_W-1]);

    generate
        if (DATA_W > IMM_W) begin : g_ldih
            assign w_ldih = {w_imm_ext[DATA_W-IMM_W-1:0], r_a[IMM_W-1:0]};
        end else begin : g_ldih_nop
            assign w_ldih = r_a;
        end
    endgenerate

    assign w_pc_inc = r_pc + PC_ONE;
    assign w_pc_rel = r_pc + w_imm_ext[PROG_ADDR_W-1:0];
    assign w_top    = r_sp[SP_W-1:0] - SP_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= PC_RST;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_neg   <= 1'b0;
            r_serr  <= 1'b0;
            r_sp    <= '0;
        end else if (!w_stall) begin
            r_pc <= w_pc_inc;
            case (w_op)
                OP_ADDI, OP_ADD: begin
                    r_a     <= w_sum[DATA_W-1:0];
                    r_carry <= w_sum[DATA_W];
                    r_neg   <= w_sum[DATA_W-1];
                    r_ovf   <= w_add_ovf;
                end
                OP_SUB: begin
                    r_a     <= w_diff[DATA_W-1:0];
                    r_carry <= w_diff[DATA_W];
                    r_neg   <= w_diff[DATA_W-1];
                    r_ovf   <= w_sub_ovf;
                end
                OP_SHFT: begin
                    if (w_imm[IMM_W-1]) begin
                        r_a     <= {r_a[DATA_W-2:0], 1'b0};
                        r_carry <= r_a[DATA_W-1];
                    end else begin
                        r_a     <= {1'b0, r_a[DATA_W-1:1]};
                        r_carry <= r_a[0];
                    end
                end
                OP_AND:           r_a <= r_a & w_operand;
                OP_XOR:           r_a <= r_a ^ w_operand;
                OP_LDI:           r_a <= w_imm_ext;
                OP_LDIH:          r_a <= w_ldih;
                OP_RDW, OP_RDWB:  r_a <= w_operand;
                OP_WRW, OP_WRWB: begin
                    if (w_int_b) begin
                        r_b <= r_a;
                    end
                end
                OP_BEQI, OP_BNEQI: begin
                    r_a <= r_a - DATA_W'(1);
                    if ((r_a == '0) == (w_op == OP_BEQI)) begin
                        r_pc <= w_pc_rel;
                    end
                end
                OP_CALL: begin
                    if (r_sp == SP_FULL) begin
                        r_serr <= 1'b1;
                    end else begin
                        r_stack[r_sp[SP_W-1:0]] <= w_pc_inc;
                        r_sp                    <= r_sp + SP_ONE;
                        r_pc                    <= w_pc_rel;
                    end
                end
                OP_RET: begin
                    if (r_sp == '0) begin
                        r_serr <= 1'b1;
                    end else begin
                        r_pc <= r_stack[w_top];
                        r_sp <= r_sp - SP_ONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xctrl2.sv
// Bench for xctrl2: directed scenarios plus a randomized instruction stream,
// all checked against a behavioural model of the instruction set.
module tb_xctrl2;

  logic        clk;
  logic        rst;
  logic [9:0]  pc;
  logic [19:0] instruction;
  logic        data_sel;
  logic        data_we;
  logic [11:0] data_addr;
  logic [31:0] data_to_rd;
  logic [31:0] data_to_wr;
  logic        data_ready;

  xctrl2 dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .instruction(instruction),
    .data_sel   (data_sel),
    .data_we    (data_we),
    .data_addr  (data_addr),
    .data_to_rd (data_to_rd),
    .data_to_wr (data_to_wr),
    .data_ready (data_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          m_pc;
  logic [31:0] m_a;
  logic [31:0] m_b;
  bit          m_c, m_v, m_n, m_e;
  int          exp_stk[$];
  bit          m_valid = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] mk(input logic [3:0] op, input logic [15:0] imm);
    return {op, imm};
  endfunction

  function automatic void decode(input logic [19:0] ins, output bit mem, output bit sel,
                                 output bit we, output logic [11:0] ea,
                                 output bit ib, output bit ic);
    logic [3:0] op;
    op  = ins[19:16];
    mem = (op inside {4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB});
    ea  = (op == 4'hA || op == 4'hB) ? 12'(m_b[11:0] + ins[11:0]) : ins[11:0];
    ib  = (ea == 12'd1);
    ic  = (ea == 12'd2);
    sel = mem && !ib && !ic;
    we  = sel && (op == 4'h9 || op == 4'hB);
  endfunction

  task automatic model_step(input logic [19:0] ins, input logic rdy, input logic [31:0] rd,
                            input logic r);
    logic [3:0]  op;
    logic [15:0] imm;
    logic [31:0] immx, opnd, opnd2;
    logic [11:0] ea;
    bit          mem, sel, we, ib, ic, zero, take;
    longint      s, ss;
    int          next_pc;
    op   = ins[19:16];
    imm  = ins[15:0];
    immx = 32'($signed(imm));
    decode(ins, mem, sel, we, ea, ib, ic);
    opnd = ib ? m_b : (ic ? {m_n, m_v, 28'b0, m_e, m_c} : rd);
    if (r) begin
      m_pc = 0; m_a = '0; m_b = '0;
      m_c = 0; m_v = 0; m_n = 0; m_e = 0;
      exp_stk.delete();
      m_valid = 1'b1;
      return;
    end
    if (sel && !rdy) return;
    next_pc = (m_pc + 1) % 1024;
    case (op)
      4'h0, 4'h1: begin
        opnd2 = (op == 4'h0) ? immx : opnd;
        s   = longint'(m_a) + longint'(opnd2);
        ss  = longint'($signed(m_a)) + longint'($signed(opnd2));
        m_a = s[31:0];
        m_c = (s > 64'sd4294967295);
        m_v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        m_n = m_a[31];
      end
      4'h2: begin
        ss  = longint'($signed(m_a)) - longint'($signed(opnd));
        m_c = (m_a < opnd);
        m_a = m_a - opnd;
        m_v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        m_n = m_a[31];
      end
      4'h3: begin
        if (imm[15]) begin m_c = m_a[31]; m_a = m_a << 1; end
        else         begin m_c = m_a[0];  m_a = m_a >> 1; end
      end
      4'h4: m_a = m_a & opnd;
      4'h5: m_a = m_a ^ opnd;
      4'h6: m_a = immx;
      4'h7: m_a = {imm, m_a[15:0]};
      4'h8, 4'hA: m_a = opnd;
      4'h9, 4'hB: if (ib) m_b = m_a;
      4'hC, 4'hD: begin
        zero = (m_a == 32'd0);
        m_a  = m_a - 32'd1;
        take = (op == 4'hC) ? zero : !zero;
        if (take) next_pc = (m_pc + int'($signed(imm))) & 1023;
      end
      4'hE: begin
        if (exp_stk.size() == 8) m_e = 1;
        else begin
          exp_stk.push_back(next_pc);
          next_pc = (m_pc + int'($signed(imm))) & 1023;
        end
      end
      default: begin
        if (exp_stk.size() == 0) m_e = 1;
        else next_pc = exp_stk.pop_back();
      end
    endcase
    m_pc = next_pc;
  endtask

  // driver: apply one cycle of inputs, check outputs against the model, advance the model
  task automatic step(input logic [19:0] ins, input logic rdy, input logic [31:0] rd,
                      input logic r);
    bit          mem, sel, we, ib, ic;
    logic [11:0] ea;
    @(negedge clk);
    instruction = ins;
    data_ready  = rdy;
    data_to_rd  = rd;
    rst         = r;
    #1;
    if (m_valid) begin
      decode(ins, mem, sel, we, ea, ib, ic);
      check("pc", 64'(pc), 64'(m_pc));
      check("data_sel", 64'(data_sel), 64'(sel));
      check("data_we", 64'(data_we), 64'(we));
      check("data_to_wr", 64'(data_to_wr), 64'(m_a));
      if (sel || !mem) check("data_addr", 64'(data_addr), 64'(ea));
    end
    model_step(ins, rdy, rd, r);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(mk(4'h6, 16'h0), 1'b1, 32'h0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [11:0] addr;
    logic [15:0] imm;
    rst = 1'b1; instruction = '0; data_ready = 1'b1; data_to_rd = '0;

    do_reset();
    after_edge();
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_rega", 64'(data_to_wr), 64'd0);

    // LDI 5; ADDI -7
    step(mk(4'h6, 16'd5), 1'b1, 32'h0, 1'b0);
    step(mk(4'h0, 16'hFFF9), 1'b1, 32'h0, 1'b0);
    after_edge();
    check("addi_neg_val", 64'(data_to_wr), 64'hFFFFFFFE);
    step(mk(4'h8, 16'd2), 1'b1, 32'h0, 1'b0);
    after_edge();
    check("addi_neg_flags", 64'(data_to_wr), 64'h80000000);

    // build 0x7FFFFFFF, then ADDI 1 overflows
    do_reset();
    step(mk(4'h6, 16'hFFFF), 1'b1, 32'h0, 1'b0);
    step(mk(4'h7, 16'h7FFF), 1'b1, 32'h0, 1'b0);
    step(mk(4'h0, 16'd1), 1'b1, 32'h0, 1'b0);
    after_edge();
    check("ovf_val", 64'(data_to_wr), 64'h80000000);
    step(mk(4'h8, 16'd2), 1'b1, 32'h0, 1'b0);
    after_edge();
    check("ovf_flags", 64'(data_to_wr), 64'hC0000000);

    // stalled read: ready low 3 cycles then high
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(mk(4'h8, 16'h0100), 1'b0, 32'hDEAD, 1'b0);
      check("stall_sel", 64'(data_sel), 64'd1);
      check("stall_addr", 64'(data_addr), 64'h100);
    end
    after_edge();
    check("stall_pc", 64'(pc), 64'd0);
    step(mk(4'h8, 16'h0100), 1'b1, 32'hA5, 1'b0);
    check("stall_sel_last", 64'(data_sel), 64'd1);
    after_edge();
    check("stall_rd", 64'(data_to_wr), 64'hA5);
    check("stall_pc_adv", 64'(pc), 64'd1);

    // nine nested calls, nine returns
    do_reset();
    for (int i = 0; i < 9; i++) step(mk(4'hE, 16'd3), 1'b1, 32'h0, 1'b0);
    after_edge();
    check("call_full_pc", 64'(pc), 64'd25);
    step(mk(4'h8, 16'd2), 1'b1, 32'h0, 1'b0);
    after_edge();
    check("call_full_err", 64'(data_to_wr), 64'h2);
    for (int k = 0; k < 8; k++) begin
      step(mk(4'hF, 16'd0), 1'b1, 32'h0, 1'b0);
      after_edge();
      check("ret_lifo", 64'(pc), 64'(22 - 3 * k));
    end
    step(mk(4'hF, 16'd0), 1'b1, 32'h0, 1'b0);
    after_edge();
    check("ret_empty_pc", 64'(pc), 64'd2);

    // pointer-relative write
    do_reset();
    step(mk(4'h6, 16'h20), 1'b1, 32'h0, 1'b0);
    step(mk(4'h9, 16'd1), 1'b1, 32'h0, 1'b0);
    check("wrw_rb_nosel", 64'(data_sel), 64'd0);
    step(mk(4'hB, 16'd4), 1'b1, 32'h0, 1'b0);
    check("wrwb_addr", 64'(data_addr), 64'h24);
    check("wrwb_we", 64'(data_we), 64'd1);
    check("wrwb_data", 64'(data_to_wr), 64'h20);
    step(mk(4'h6, 16'h33), 1'b1, 32'h0, 1'b0);
    step(mk(4'hB, 16'd4), 1'b1, 32'h0, 1'b0);
    step(mk(4'h8, 16'd1), 1'b1, 32'h0, 1'b0);
    after_edge();
    check("wrwb_regb_kept", 64'(data_to_wr), 64'h20);

    // reset during stalled access
    do_reset();
    step(mk(4'h6, 16'hFFFF), 1'b1, 32'h0, 1'b0);
    step(mk(4'h0, 16'd1), 1'b1, 32'h0, 1'b0);
    step(mk(4'h6, 16'd9), 1'b1, 32'h0, 1'b0);
    step(mk(4'hE, 16'd5), 1'b1, 32'h0, 1'b0);
    step(mk(4'h8, 16'h0100), 1'b0, 32'h0, 1'b0);
    step(mk(4'h8, 16'h0100), 1'b0, 32'h0, 1'b1);
    after_edge();
    check("rst_stall_pc", 64'(pc), 64'd0);
    check("rst_stall_rega", 64'(data_to_wr), 64'd0);
    step(mk(4'h8, 16'd2), 1'b1, 32'h0, 1'b0);
    after_edge();
    check("rst_stall_flags", 64'(data_to_wr), 64'd0);
    step(mk(4'hF, 16'd0), 1'b1, 32'h0, 1'b0);
    after_edge();
    check("rst_stall_stack_empty", 64'(pc), 64'd2);

    // randomized instruction stream
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       addr = 12'd1;
        1:       addr = 12'd2;
        default: addr = 12'($urandom_range(3, 4095));
      endcase
      if (op == 4'hA || op == 4'hB)
        imm = {4'($urandom), 12'(addr - m_b[11:0])};
      else if (op inside {4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9})
        imm = {4'($urandom), addr};
      else
        imm = 16'($urandom);
      step(mk(op, imm), ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
